memseq: RTL and testbench

- Parametrised byte-serial load/store sequencer for the next-generation robin CPU.
- Replaces the hand-coded loadb3..0 and storb3..0 state chains.
- Accepts one access request of 1, 2, 4 or DATA_BYTES bytes and moves it big-endian (MSB at lowest address) over the 8-bit dual-address block RAM port.
- Sign- or zero-extends load results; memory read latency is configurable.

---
 rtl/memseq.sv | 180 ++++++++++++++++++
 tb/tb_memseq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/memseq.sv
// memseq: byte-serial load/store sequencer for the robin CPU.
// Moves one 1, 2, 4 or DATA_BYTES byte access big-endian (MSB at the lowest
// address) over an 8-bit block RAM port with separate read/write addresses.
// Load results are sign- or zero-extended to 8*DATA_BYTES bits.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req_*           request handshake (valid/ready), kind, size, sign, addr, data
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       load result, held until the next load completes
//   busy            access in progress
//   mem_*           8-bit RAM port (read addr, write addr, write data/strobe,
//                   read data returning READ_LATENCY edges after mem_raddr)
module memseq #(
  parameter int addr_width   = 9,
  parameter int DATA_BYTES   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    busy,
  output logic [addr_width-1:0]   mem_raddr,
  output logic [addr_width-1:0]   mem_waddr,
  output logic [7:0]              mem_data_in,
  output logic                    mem_write,
  input  logic [7:0]              mem_data_out
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  state;
  logic [CW-1:0]           n_r;        // byte count of the current access
  logic [CW-1:0]           issued;     // addresses issued / bytes written so far
  logic [CW-1:0]           captured;   // read bytes captured so far
  logic                    signed_r;
  logic [W-1:0]            acc;        // read accumulator, MSB first
  logic [W-1:0]            wbuf;       // remaining store bytes, left-aligned
  logic [READ_LATENCY-1:0] vpipe;      // one bit per read byte in flight

  logic [CW-1:0]           req_n;
  int unsigned             req_n_int;
  int unsigned             n_int;
  logic [W-1:0]            req_aligned;
  logic [W-1:0]            load_data;
  logic [W-1:0]            load_ext;
  logic                    sign_bit;
  logic                    accept;
  logic                    issue;
  logic                    capture;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign n_int     = 32'(n_r);

  // Byte count for the incoming request, clamped to the data path width.
  always_comb begin
    req_n_int = 1;
    case (req_size)
      2'd0:    req_n_int = 1;
      2'd1:    req_n_int = 2;
      2'd2:    req_n_int = 4;
      default: req_n_int = DATA_BYTES;
    endcase
    if (req_n_int > DATA_BYTES) req_n_int = DATA_BYTES;
    req_n = CW'(req_n_int);
    // Left-align the used store bytes so the MSB always leaves from the top.
    req_aligned = req_wdata << (8 * (DATA_BYTES - req_n_int));
  end

  assign issue   = (accept && !req_write) || ((state == READ) && (issued < n_r));
  assign capture = vpipe[READ_LATENCY-1];
  assign load_data = {acc[W-9:0], mem_data_out};

  // Extension of the final load value: bytes at or above n_r are filled.
  always_comb begin
    sign_bit = 1'b0;
    load_ext = '0;
    for (int unsigned b = 0; b < DATA_BYTES; b++) begin
      if (b == n_int - 1) sign_bit = signed_r && load_data[8*b+7];
    end
    for (int unsigned b = 0; b < DATA_BYTES; b++) begin
      if (b < n_int) load_ext[8*b +: 8] = load_data[8*b +: 8];
      else           load_ext[8*b +: 8] = {8{sign_bit}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      n_r         <= '0;
      issued      <= '0;
      captured    <= '0;
      signed_r    <= 1'b0;
      acc         <= '0;
      wbuf        <= '0;
      vpipe       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      vpipe[0] <= issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];

      if (capture) begin
        acc      <= load_data;
        captured <= captured + CW'(1);
      end

      case (state)
        IDLE: begin
          mem_write <= 1'b0;
          if (accept) begin
            n_r      <= req_n;
            signed_r <= req_signed;
            issued   <= CW'(1);
            captured <= '0;
            if (req_write) begin
              mem_waddr   <= req_addr;
              mem_data_in <= req_aligned[W-1 -: 8];
              wbuf        <= req_aligned << 8;
              mem_write   <= 1'b1;
              if (req_n == CW'(1)) rsp_valid <= 1'b1;
              else                 state     <= WRITE;
            end else begin
              mem_raddr <= req_addr;
              state     <= READ;
            end
          end
        end

        READ: begin
          if (issued < n_r) begin
            mem_raddr <= mem_raddr + addr_width'(1);
            issued    <= issued + CW'(1);
          end
          if (capture && (captured == n_r - CW'(1))) begin
            rsp_rdata <= load_ext;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end

        WRITE: begin
          mem_waddr   <= mem_waddr + addr_width'(1);
          mem_data_in <= wbuf[W-1 -: 8];
          wbuf        <= wbuf << 8;
          mem_write   <= 1'b1;
          issued      <= issued + CW'(1);
          // Last byte goes out now; returning to IDLE lets a follow-on store
          // be accepted in the response cycle with no write gap.
          if (issued == n_r - CW'(1)) begin
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memseq.sv
module tb_memseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [8:0]  mem_raddr;
  logic [8:0]  mem_waddr;
  logic [7:0]  mem_data_in;
  logic        mem_write;
  logic [7:0]  mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model: one register stage gives two edges from raddr to sampling.
  logic [7:0] mem [512];
  logic [7:0] rd_q;
  logic       pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    rd_q <= mem[mem_raddr];
    if (mem_write) mem[mem_waddr] <= mem_data_in;
    if (pl_en)     mem[pl_addr]   <= pl_data;
  end
  assign mem_data_out = rd_q;

  always #5 clk = ~clk;

  memseq #(.addr_width(9), .DATA_BYTES(4), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if ({rsp_valid, mem_write, rsp_rdata, mem_raddr, mem_waddr, mem_data_in} !== '0) begin
      n_fail++; $display("FAIL rst_outputs got=%b/%b/%h/%h/%h/%h exp=all zero",
                         rsp_valid, mem_write, rsp_rdata, mem_raddr, mem_waddr, mem_data_in);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_load_byte(input logic sg, input logic [31:0] exp);
    poke(9'h010, 8'h85);
    set_req(1'b0, 2'd0, sg, 9'h010, '0);
    @(negedge clk); req_valid = 1'b0;
    n_checks++; if (mem_raddr !== 9'h010) begin n_fail++; $display("FAIL lb_raddr got=%h exp=010", mem_raddr); end
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lb_edge0 busy=%b rsp=%b exp 1/0", busy, rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lb_early_rsp got=%b exp=0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lb_rsp got=%b exp=1", rsp_valid); end
    n_checks++; if (rsp_rdata !== exp) begin n_fail++; $display("FAIL lb_rdata got=%h exp=%h", rsp_rdata, exp); end
    n_checks++; if (req_ready !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL lb_ready_wr ready=%b wr=%b exp 1/0", req_ready, mem_write); end
  endtask

  task automatic test_load_half_signed;
    poke(9'h020, 8'h80);
    poke(9'h021, 8'h01);
    set_req(1'b0, 2'd1, 1'b1, 9'h020, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req_valid = 1'b0;
      n_checks++; if (rsp_valid !== (k == 3)) begin n_fail++; $display("FAIL lh_rsp k=%0d got=%b exp=%b", k, rsp_valid, (k == 3)); end
    end
    n_checks++; if (rsp_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata got=%h exp=FFFF8001", rsp_rdata); end
  endtask

  task automatic test_load_word_wrap;
    logic [8:0] exp_ra [4];
    exp_ra = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    poke(9'h1FE, 8'h12); poke(9'h1FF, 8'h34); poke(9'h000, 8'h56); poke(9'h001, 8'h78);
    set_req(1'b0, 2'd2, 1'b0, 9'h1FE, '0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); req_valid = 1'b0;
      if (k < 4) begin
        n_checks++; if (mem_raddr !== exp_ra[k]) begin n_fail++; $display("FAIL lw_raddr k=%0d got=%h exp=%h", k, mem_raddr, exp_ra[k]); end
      end
      n_checks++; if (rsp_valid !== (k == 5)) begin n_fail++; $display("FAIL lw_rsp k=%0d got=%b exp=%b", k, rsp_valid, (k == 5)); end
      if (k == 5) begin
        n_checks++; if (rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL lw_rdata got=%h exp=12345678", rsp_rdata); end
      end
    end
    n_checks++; if (mem_raddr !== 9'h001) begin n_fail++; $display("FAIL lw_raddr_hold got=%h exp=001", mem_raddr); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_wa [6];
    logic [7:0] exp_wd [6];
    exp_wa = '{9'h020, 9'h021, 9'h040, 9'h041, 9'h042, 9'h043};
    exp_wd = '{8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    set_req(1'b1, 2'd1, 1'b0, 9'h020, 32'h0000BEEF);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (k < 6) begin
        n_checks++; if (mem_write !== 1'b1 || mem_waddr !== exp_wa[k] || mem_data_in !== exp_wd[k]) begin
          n_fail++; $display("FAIL st_write k=%0d got=%b/%h/%h exp=1/%h/%h", k, mem_write, mem_waddr, mem_data_in, exp_wa[k], exp_wd[k]);
        end
      end else begin
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL st_write_end got=%b exp=0", mem_write); end
      end
      n_checks++; if (rsp_valid !== (k == 1 || k == 5)) begin n_fail++; $display("FAIL st_rsp k=%0d got=%b exp=%b", k, rsp_valid, (k == 1 || k == 5)); end
      if (k == 1) begin
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready got=%b exp=1", req_ready); end
        set_req(1'b1, 2'd2, 1'b0, 9'h040, 32'hCAFEF00D);
      end
    end
    n_checks++; if (mem[9'h020] !== 8'hBE || mem[9'h021] !== 8'hEF || mem[9'h043] !== 8'h0D) begin
      n_fail++; $display("FAIL st_mem got=%h/%h/%h exp=BE/EF/0D", mem[9'h020], mem[9'h021], mem[9'h043]);
    end
    n_checks++; if (rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL st_rdata_kept got=%h exp=12345678", rsp_rdata); end
  endtask

  task automatic test_busy_reject;
    int rsp_count;
    rsp_count = 0;
    set_req(1'b0, 2'd2, 1'b0, 9'h1FE, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) set_req(1'b0, 2'd0, 1'b0, 9'h010, '0);
      if (k >= 1 && k <= 4) begin
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL br_ready k=%0d got=%b exp=0", k, req_ready); end
      end
      if (k == 4) req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        n_checks++; if (k != 5 || rsp_rdata !== 32'h12345678) begin
          n_fail++; $display("FAIL br_rsp k=%0d rdata=%h exp k=5 rdata=12345678", k, rsp_rdata);
        end
      end
    end
    n_checks++; if (rsp_count != 1) begin n_fail++; $display("FAIL br_rsp_count got=%0d exp=1", rsp_count); end
    n_checks++; if (mem_raddr !== 9'h001) begin n_fail++; $display("FAIL br_raddr got=%h exp=001", mem_raddr); end
  endtask

  task automatic test_reset_mid_store;
    for (int i = 0; i < 4; i++) poke(9'(9'h080 + i), 8'h00);
    set_req(1'b1, 2'd2, 1'b0, 9'h080, 32'h11223344);
    @(negedge clk); req_valid = 1'b0;
    n_checks++; if (mem_write !== 1'b1 || mem_waddr !== 9'h080 || mem_data_in !== 8'h11) begin
      n_fail++; $display("FAIL rs_byte0 got=%b/%h/%h exp=1/080/11", mem_write, mem_waddr, mem_data_in);
    end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_waddr !== 9'h081 || mem_data_in !== 8'h22) begin
      n_fail++; $display("FAIL rs_byte1 got=%b/%h/%h exp=1/081/22", mem_write, mem_waddr, mem_data_in);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({req_ready, busy, rsp_valid, mem_write, rsp_rdata, mem_raddr, mem_waddr, mem_data_in} !== '0) begin
      n_fail++; $display("FAIL rs_outputs got=%b/%b/%b/%b/%h/%h/%h/%h exp=all zero",
                         req_ready, busy, rsp_valid, mem_write, rsp_rdata, mem_raddr, mem_waddr, mem_data_in);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_write !== 1'b0) begin
        n_fail++; $display("FAIL rs_after k=%0d ready=%b rsp=%b wr=%b exp 1/0/0", k, req_ready, rsp_valid, mem_write);
      end
    end
    n_checks++; if (mem[9'h080] !== 8'h11 || mem[9'h082] !== 8'h00 || mem[9'h083] !== 8'h00) begin
      n_fail++; $display("FAIL rs_mem got=%h/%h/%h exp=11/00/00", mem[9'h080], mem[9'h082], mem[9'h083]);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_load_byte(1'b0, 32'h00000085);
    test_load_byte(1'b1, 32'hFFFFFF85);
    test_load_half_signed();
    test_load_word_wrap();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
